oled_power_sequencer: RTL
=========================

Name: oled_power_sequencer

Overview:
- Controls the power-up and power-down of the Zedboard 128x32 SSD1306 OLED.
- Drives the VDD, VBAT and RES rails with timed delays and issues the fixed init and shutdown command bytes through the byte-level SPI serializer.
- Once the display is on, it hands the serializer to the host byte stream (AXI register path), acting as a two-source arbiter.

Parameters:
- T_VDD_CYC, 100000: cycles from VDD on to first command (1 ms @100 MHz).
- T_RES_CYC, 100000: cycles RES is held low.
- T_VBAT_CYC, 10000000: cycles of VBAT settle after VBAT on, and after VBAT off.
- CNT_W, 24: timer width; must satisfy 2^CNT_W > max(T_*).

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  asynchronous reset, active-high
- start_on  in  1  one-cycle pulse: begin power-up
- start_off  in  1  one-cycle pulse: begin power-down
- busy  out  1  sequencing in progress
- ready  out  1  display on; host path granted
- host_byte  in  8  host byte
- host_dc  in  1  host D/C (1=data)
- host_valid  in  1  host byte valid
- host_ready  out  1  host byte accepted
- spi_byte  out  8  byte to serializer
- spi_dc  out  1  D/C to serializer/pin
- spi_valid  out  1  byte valid
- spi_ready  in  1  serializer accepts
- spi_busy  in  1  serializer still shifting
- VDD  out  1  logic rail enable, active-low (0 = on)
- VBAT  out  1  panel rail enable, active-low (0 = on)
- RES  out  1  SSD1306 reset, active-low

Behaviour:
- Reset values: VDD=1, VBAT=1, RES=1, spi_valid=0, spi_byte=0, spi_dc=0, host_ready=0, busy=0, ready=0, state=OFF, pending_off=0.
- Reset mid-operation drops both rails immediately. This is accepted.
- Handshake: a byte transfers on spi_valid&&spi_ready. Once raised, spi_valid and spi_byte stay stable until the transfer completes.
- Command ROM (package), index:byte:
  0:AE, 1:8D, 2:14, 3:D9, 4:F1, 5:81, 6:0F, 7:A0, 8:C0, 9:DA, 10:00, 11:AF.
- All sequencer bytes are sent with spi_dc=0.
- "Drain" means wait for spi_busy==0 before the next rail or timer action.
- States and transitions:
  - OFF: start_on && !start_off -> VDD_WAIT, with VDD:=0 and timer loaded. Otherwise stay.
  - VDD_WAIT: when the timer expires -> CMD, idx=0, end=0, next=RES_LOW.
  - CMD: send ROM[idx..end] one per handshake. After the last byte completes and drains -> next.
  - RES_LOW: RES:=0 for T_RES_CYC, then RES:=1 -> CMD, idx=1..4, next=VBAT_ON.
  - VBAT_ON: VBAT:=0, wait T_VBAT_CYC -> CMD, idx=5..11, next=ON.
  - ON: ready=1. The host mux is active: spi_byte=host_byte, spi_dc=host_dc, spi_valid=host_valid, host_ready=spi_ready.
  - ON exit: on start_off or pending_off, leave only in a cycle where host_valid==0 or the host handshake completes. Exit goes to CMD, idx=0..0, next=VBAT_OFF.
  - VBAT_OFF: drain, VBAT:=1, wait T_VBAT_CYC -> VDD_OFF.
  - VDD_OFF: VDD:=1 -> OFF.
- busy=1 in every state except OFF and ON. host_ready=0 outside ON.
- Timer: loaded with T-1, decremented each cycle, expires at 0. Exactly T cycles per phase.
- start_off during power-up sets pending_off. The sequence completes to ON, then powers off immediately; ready is high for 1 cycle. pending_off clears on leaving ON.
- start_on outside OFF is ignored. start_off in OFF is ignored. Simultaneous start_on and start_off in OFF: off wins, stays OFF.

Decomposition:
- Package oled_pkg holds:
  - state enum;
  - OLED_CMD_ROM[12] constant;
  - index constants CMD_DISPOFF=0, CMD_PRE_FIRST=1, CMD_PRE_LAST=4, CMD_POST_FIRST=5, CMD_POST_LAST=11.
- One sub-module: oled_phase_timer (load, value, expired), using parameter CNT_W.
- The FSM and host mux stay in the top level.

Test Plan (T_VDD_CYC=10, T_RES_CYC=5, T_VBAT_CYC=20; serializer model with spi_ready=1 and spi_busy high 8 cycles per byte):
- start_on -> VDD falls next cycle; AE is sent 10 cycles later; RES is low exactly 5 cycles; then 8D 14 D9 F1; VBAT falls; 20 cycles later 81 0F A0 C0 DA 00 AF; then ready=1, busy=0.
- In ON: host sends 0x55 with dc=1 while spi_ready is low for 3 cycles -> spi_valid and spi_byte stay stable; host_ready pulses once; spi_dc=1.
- From ON, start_off while a host byte is pending -> the host byte completes first, then AE; VBAT rises after drain; VDD rises after 20 cycles; state returns to OFF.
- start_off at idx=2 of the pre-charge commands -> the remaining sequence completes, ready is high for 1 cycle, then the AE shutdown runs.
- Simultaneous start_on and start_off in OFF -> no output changes; start_on during busy is ignored.
- Assert s00_axi_areset during VBAT_ON -> VDD, VBAT and RES go to 1 and spi_valid=0 asynchronously; a fresh start_on after release runs the full sequence.

Source files
------------

// File: rtl/oled_power_sequencer_pkg.sv
// rtl/oled_power_sequencer_pkg.sv - OLED sequencer states, SSD1306 command ROM and index constants
package oled_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_VDD_WAIT,
        ST_CMD,
        ST_RES_LOW,
        ST_VBAT_ON,
        ST_ON,
        ST_VBAT_OFF,
        ST_VDD_OFF
    } oled_state_e;

    localparam int OLED_CMD_N = 12;

    // Display off, charge pump on, pre-charge, contrast, remap, COM config, display on.
    localparam logic [7:0] OLED_CMD_ROM [OLED_CMD_N] = '{
        8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
        8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF
    };

    localparam logic [3:0] CMD_DISPOFF    = 4'd0;
    localparam logic [3:0] CMD_PRE_FIRST  = 4'd1;
    localparam logic [3:0] CMD_PRE_LAST   = 4'd4;
    localparam logic [3:0] CMD_POST_FIRST = 4'd5;
    localparam logic [3:0] CMD_POST_LAST  = 4'd11;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        return (idx < 4'd12) ? OLED_CMD_ROM[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/oled_power_sequencer_if.sv
// rtl/oled_power_sequencer_if.sv - control, host byte stream and serializer byte stream bundle
interface oled_power_sequencer_if;

    logic       start_on;
    logic       start_off;
    logic       busy;
    logic       ready;
    logic [7:0] host_byte;
    logic       host_dc;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] spi_byte;
    logic       spi_dc;
    logic       spi_valid;
    logic       spi_ready;
    logic       spi_busy;
    logic       VDD;
    logic       VBAT;
    logic       RES;

    modport master (
        output start_on, start_off, host_byte, host_dc, host_valid, spi_ready, spi_busy,
        input  busy, ready, host_ready, spi_byte, spi_dc, spi_valid, VDD, VBAT, RES
    );

    modport slave (
        input  start_on, start_off, host_byte, host_dc, host_valid, spi_ready, spi_busy,
        output busy, ready, host_ready, spi_byte, spi_dc, spi_valid, VDD, VBAT, RES
    );

endinterface

// File: rtl/oled_power_sequencer_timer.sv
// rtl/oled_power_sequencer_timer.sv - down-counting phase timer, expired while the count is zero
module oled_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/oled_power_sequencer.sv
// rtl/oled_power_sequencer.sv - SSD1306 rail/reset sequencing with command ROM and host byte arbitration
module oled_power_sequencer
    import oled_pkg::*;
#(
    parameter int T_VDD_CYC  = 100000,
    parameter int T_RES_CYC  = 100000,
    parameter int T_VBAT_CYC = 10000000,
    parameter int CNT_W      = 24
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    oled_power_sequencer_if.slave bus
);

    oled_state_e state_q, next_q;
    logic [3:0]  idx_q, last_q;
    logic [7:0]  spi_byte_q;
    logic        spi_valid_q;
    logic        vdd_q, vbat_q, res_q;
    logic        busy_q, ready_q, pending_off_q;

    logic             timer_load_d;
    logic [CNT_W-1:0] timer_val_d;
    logic             timer_expired;
    logic             cmd_done;
    logic             on_exit;
    logic             up_phase;

    assign cmd_done = (state_q == ST_CMD) && !spi_valid_q && !bus.spi_busy;
    // The host byte in flight must finish (or never have started) before the shutdown ROM takes the bus.
    assign on_exit  = (state_q == ST_ON) && (bus.start_off || pending_off_q) &&
                      (!bus.host_valid || bus.spi_ready);
    assign up_phase = (state_q == ST_VDD_WAIT) || (state_q == ST_RES_LOW) ||
                      (state_q == ST_VBAT_ON) || (state_q == ST_ON) ||
                      ((state_q == ST_CMD) && (next_q != ST_VBAT_OFF));

    always_comb begin
        timer_load_d = 1'b0;
        timer_val_d  = '0;
        case (state_q)
            ST_OFF: begin
                if (bus.start_on && !bus.start_off) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = CNT_W'(T_VDD_CYC - 1);
                end
            end
            ST_CMD: begin
                if (cmd_done) begin
                    case (next_q)
                        ST_RES_LOW: begin
                            timer_load_d = 1'b1;
                            timer_val_d  = CNT_W'(T_RES_CYC - 1);
                        end
                        ST_VBAT_ON, ST_VBAT_OFF: begin
                            timer_load_d = 1'b1;
                            timer_val_d  = CNT_W'(T_VBAT_CYC - 1);
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    oled_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i     (s00_axi_aclk),
        .rst_i     (s00_axi_areset),
        .load_i    (timer_load_d),
        .value_i   (timer_val_d),
        .expired_o (timer_expired)
    );

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            state_q       <= ST_OFF;
            next_q        <= ST_OFF;
            idx_q         <= '0;
            last_q        <= '0;
            spi_byte_q    <= '0;
            spi_valid_q   <= 1'b0;
            vdd_q         <= 1'b1;
            vbat_q        <= 1'b1;
            res_q         <= 1'b1;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            pending_off_q <= 1'b0;
        end else begin
            if (up_phase && bus.start_off) begin
                pending_off_q <= 1'b1;
            end
            case (state_q)
                ST_OFF: begin
                    if (bus.start_on && !bus.start_off) begin
                        vdd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_VDD_WAIT;
                    end
                end
                ST_VDD_WAIT: begin
                    if (timer_expired) begin
                        state_q     <= ST_CMD;
                        idx_q       <= CMD_DISPOFF;
                        last_q      <= CMD_DISPOFF;
                        next_q      <= ST_RES_LOW;
                        spi_byte_q  <= cmd_byte(CMD_DISPOFF);
                        spi_valid_q <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (spi_valid_q && bus.spi_ready) begin
                        if (idx_q == last_q) begin
                            spi_valid_q <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            spi_byte_q <= cmd_byte(idx_q + 4'd1);
                        end
                    end else if (cmd_done) begin
                        state_q <= next_q;
                        case (next_q)
                            ST_RES_LOW:  res_q  <= 1'b0;
                            ST_VBAT_ON:  vbat_q <= 1'b0;
                            ST_VBAT_OFF: vbat_q <= 1'b1;
                            ST_ON: begin
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RES_LOW: begin
                    if (timer_expired) begin
                        res_q       <= 1'b1;
                        state_q     <= ST_CMD;
                        idx_q       <= CMD_PRE_FIRST;
                        last_q      <= CMD_PRE_LAST;
                        next_q      <= ST_VBAT_ON;
                        spi_byte_q  <= cmd_byte(CMD_PRE_FIRST);
                        spi_valid_q <= 1'b1;
                    end
                end
                ST_VBAT_ON: begin
                    if (timer_expired) begin
                        state_q     <= ST_CMD;
                        idx_q       <= CMD_POST_FIRST;
                        last_q      <= CMD_POST_LAST;
                        next_q      <= ST_ON;
                        spi_byte_q  <= cmd_byte(CMD_POST_FIRST);
                        spi_valid_q <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (on_exit) begin
                        ready_q       <= 1'b0;
                        busy_q        <= 1'b1;
                        pending_off_q <= 1'b0;
                        state_q       <= ST_CMD;
                        idx_q         <= CMD_DISPOFF;
                        last_q        <= CMD_DISPOFF;
                        next_q        <= ST_VBAT_OFF;
                        spi_byte_q    <= cmd_byte(CMD_DISPOFF);
                        spi_valid_q   <= 1'b1;
                    end
                end
                ST_VBAT_OFF: begin
                    if (timer_expired) begin
                        vdd_q   <= 1'b1;
                        state_q <= ST_VDD_OFF;
                    end
                end
                ST_VDD_OFF: begin
                    busy_q        <= 1'b0;
                    pending_off_q <= 1'b0;
                    state_q       <= ST_OFF;
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end

    // Once on, the host stream passes straight through to the serializer.
    assign bus.spi_valid  = (state_q == ST_ON) ? bus.host_valid : spi_valid_q;
    assign bus.spi_byte   = (state_q == ST_ON) ? bus.host_byte  : spi_byte_q;
    assign bus.spi_dc     = (state_q == ST_ON) ? bus.host_dc    : 1'b0;
    assign bus.host_ready = (state_q == ST_ON) && bus.spi_ready;
    assign bus.busy       = busy_q;
    assign bus.ready      = ready_q;
    assign bus.VDD        = vdd_q;
    assign bus.VBAT       = vbat_q;
    assign bus.RES        = res_q;

endmodule
